// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if
//   Fetch-stage instruction bus between a core's fetch unit (master) and
//   the program memory (slave).
//
//   req     fetch request, held by the master until granted
//   gnt     request accepted in any cycle where req && gnt
//   addr    byte address of the fetch; bits [1:0] are ignored by the memory
//   rdata   response word, meaningful while rvalid is high
//   rvalid  one-cycle response strobe, one per grant, in grant order
//   err     response address was out of range; qualifies rvalid
interface instr_mem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rdata,
    input  rvalid,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rdata,
    output rvalid,
    output err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Memory side of the fetch-stage instruction bus. Word fetches are read
//   from an internal array in the grant cycle and returned in grant order
//   after a fixed LATENCY. The number of granted-but-unanswered requests
//   is bounded by NUM_OUTSTANDING. A side load port fills the array.
//
//   Optional feature macro: IMEM_GNT_STALL_EN
//     When defined, gnt is held low for STALL_CYCLES cycles after every
//     grant to emulate a slow memory.
//
//   Ports:
//     clk            clock, all state on the rising edge
//     rstn           asynchronous active-low reset
//     bus            instruction bus, slave side (req/gnt/addr/rdata/rvalid/err)
//     load_we_i      array write strobe
//     load_addr_i    byte address of the array write; bits [1:0] ignored
//     load_wdata_i   array write data
//     outstanding_o  current granted-but-unanswered request count
module instr_mem_responder #(
  parameter int          MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          NUM_OUTSTANDING = 2,
  parameter int          STALL_CYCLES    = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  instr_mem_responder_if.slave        bus,
  input  logic                        load_we_i,
  input  logic [31:0]                 load_addr_i,
  input  logic [31:0]                 load_wdata_i,
  output logic [2:0]                  outstanding_o
);

  localparam int          IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] DEPTH   = 30'(MEM_WORDS);
  localparam logic [2:0]  MAX_OUT = 3'(NUM_OUTSTANDING);

  logic [31:0]      mem [MEM_WORDS];

  logic [31:0]      req_off;
  logic             req_in_range;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      rd_data;

  logic [31:0]      load_off;
  logic             load_in_range;
  logic [IDX_W-1:0] load_idx;

  logic             gnt;
  logic             stall_free;
  logic [2:0]       count;
  logic             rvalid;

  logic             pipe_vld  [LATENCY];
  logic [31:0]      pipe_data [LATENCY];
  logic             pipe_err  [LATENCY];

  // Byte offsets wrap on subtraction, so the addr >= BASE_ADDR test is what
  // rejects addresses below the base; bits [1:0] of the offset only select a
  // byte or halfword inside the word and are dropped.
  assign req_off       = bus.addr - BASE_ADDR;
  assign req_in_range  = (bus.addr >= BASE_ADDR) && (req_off[31:2] < DEPTH);
  assign req_idx       = req_off[IDX_W+1:2];

  assign load_off      = load_addr_i - BASE_ADDR;
  assign load_in_range = (load_addr_i >= BASE_ADDR) && (load_off[31:2] < DEPTH);
  assign load_idx      = load_off[IDX_W+1:2];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{req_off[1:0], load_off[1:0]};

  // The array is not reset. A same-cycle load and fetch of one word reads
  // the pre-write contents because the read below is taken before the edge.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_idx] <= load_wdata_i;
    end
  end

  assign rd_data = req_in_range ? mem[req_idx] : 32'h0000_0000;

`ifdef IMEM_GNT_STALL_EN
  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES);

  logic [2:0] stall_cnt;

  // Every grant blocks the next STALL_CYCLES cycles regardless of req or
  // count, exercising the initiator's req-without-gnt path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 3'd0;
    end else if (gnt) begin
      stall_cnt <= STALL_LOAD;
    end else if (stall_cnt != 3'd0) begin
      stall_cnt <= stall_cnt - 3'd1;
    end
  end

  assign stall_free = (stall_cnt == 3'd0);
`else
  assign stall_free = 1'b1;
`endif

  // gnt looks only at req and registered state, so the initiator never sees
  // a combinational path from its own addr or from a same-cycle response.
  assign gnt = bus.req && (count < MAX_OUT) && stall_free;

  // Response pipeline: stage 0 captures the read in the grant cycle and the
  // last stage drives the bus. Data/err stages only move when the stage
  // feeding them holds a response, so rdata/err keep their last value while
  // rvalid is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_data[i] <= 32'h0000_0000;
        pipe_err[i]  <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= gnt;
      if (gnt) begin
        pipe_data[0] <= rd_data;
        pipe_err[0]  <= !req_in_range;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign rvalid = pipe_vld[LATENCY-1];

  // A grant and a response in the same cycle cancel out, which lets
  // LATENCY=1 sustain one grant per cycle once the pipe is primed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 3'd0;
    end else if (gnt && !rvalid) begin
      count <= count + 3'd1;
    end else if (!gnt && rvalid) begin
      count <= count - 3'd1;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rvalid    = rvalid;
  assign bus.rdata     = pipe_data[LATENCY-1];
  assign bus.err       = pipe_err[LATENCY-1];
  assign outstanding_o = count;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
//   Drives two responders sharing clock, reset and load port:
//     index 0: LATENCY=1, NUM_OUTSTANDING=2
//     index 1: LATENCY=3, NUM_OUTSTANDING=2
//   A per-cycle monitor models gnt, rvalid and the outstanding count, pushes
//   the expected {err, data} of every grant into a queue and pops it when
//   the response is due. With IMEM_GNT_STALL_EN defined both instances use
//   STALL_CYCLES=2 and the model includes the stall counter.
module tb_instr_mem_responder;

  localparam int LAT_A   = 1;
  localparam int LAT_B   = 3;
  localparam int NOUT    = 2;
  localparam int STALL_N = 2;
  localparam int WORDS   = 4096;

  logic        clk;
  logic        rstn;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic [2:0]  outstanding_a;
  logic [2:0]  outstanding_b;

  logic        req_w    [2];
  logic [31:0] addr_w   [2];
  logic        gnt_w    [2];
  logic        rvalid_w [2];
  logic [31:0] rdata_w  [2];
  logic        err_w    [2];
  logic [2:0]  out_w    [2];

  instr_mem_responder_if bus_a ();
  instr_mem_responder_if bus_b ();

  assign bus_a.req   = req_w[0];
  assign bus_a.addr  = addr_w[0];
  assign bus_b.req   = req_w[1];
  assign bus_b.addr  = addr_w[1];
  assign gnt_w[0]    = bus_a.gnt;
  assign gnt_w[1]    = bus_b.gnt;
  assign rvalid_w[0] = bus_a.rvalid;
  assign rvalid_w[1] = bus_b.rvalid;
  assign rdata_w[0]  = bus_a.rdata;
  assign rdata_w[1]  = bus_b.rdata;
  assign err_w[0]    = bus_a.err;
  assign err_w[1]    = bus_b.err;
  assign out_w[0]    = outstanding_a;
  assign out_w[1]    = outstanding_b;

  instr_mem_responder #(
    .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(LAT_A),
    .NUM_OUTSTANDING(NOUT), .STALL_CYCLES(STALL_N)
  ) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outstanding_a)
  );

  instr_mem_responder #(
    .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(LAT_B),
    .NUM_OUTSTANDING(NOUT), .STALL_CYCLES(STALL_N)
  ) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outstanding_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [31:0] model_mem [WORDS];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  int          mcount    [2];
  logic [3:0]  mvld      [2];
  int          mstall    [2];
  logic [32:0] last_resp [2];

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] modelRead(input logic [31:0] a);
    if ((a >> 2) < 32'(WORDS)) return {1'b0, model_mem[a[13:2]]};
    return {1'b1, 32'h0000_0000};
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic pushExp(input int d, input logic [32:0] e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic popExp(input int d, output logic [32:0] e);
    e = 'x;
    if (d == 0) begin
      if (q0.size() > 0) e = q0.pop_front();
    end else begin
      if (q1.size() > 0) e = q1.pop_front();
    end
  endtask

  task automatic monitorStep(input int d);
    logic        exp_gnt;
    logic        exp_vld;
    logic [32:0] e;
    if (!rstn) begin
      mcount[d]    = 0;
      mvld[d]      = 4'b0;
      mstall[d]    = 0;
      last_resp[d] = 33'h0;
      if (d == 0) q0.delete();
      else        q1.delete();
      checkOutput("rst_gnt", 32'(gnt_w[d]), 32'(req_w[d]));
      checkOutput("rst_rvalid", 32'(rvalid_w[d]), 32'h0);
      checkOutput("rst_rdata", rdata_w[d], 32'h0);
      checkOutput("rst_err", 32'(err_w[d]), 32'h0);
      checkOutput("rst_outstanding", 32'(out_w[d]), 32'h0);
      return;
    end
    exp_gnt = req_w[d] && (mcount[d] < NOUT) && (mstall[d] == 0);
    exp_vld = mvld[d][latOf(d)-1];
    checkOutput(d == 0 ? "gnt_a" : "gnt_b", 32'(gnt_w[d]), 32'(exp_gnt));
    checkOutput(d == 0 ? "rvalid_a" : "rvalid_b", 32'(rvalid_w[d]), 32'(exp_vld));
    checkOutput(d == 0 ? "outstanding_a" : "outstanding_b", 32'(out_w[d]), 32'(mcount[d]));
    if (exp_vld) begin
      popExp(d, e);
      checkOutput(d == 0 ? "rdata_a" : "rdata_b", rdata_w[d], e[31:0]);
      checkOutput(d == 0 ? "err_a" : "err_b", 32'(err_w[d]), 32'(e[32]));
      last_resp[d] = e;
    end else begin
      checkOutput("rdata_hold", rdata_w[d], last_resp[d][31:0]);
      checkOutput("err_hold", 32'(err_w[d]), 32'(last_resp[d][32]));
    end
    if (exp_gnt) pushExp(d, modelRead(addr_w[d]));
    mcount[d] = mcount[d] + int'(exp_gnt) - int'(exp_vld);
    mvld[d]   = {mvld[d][2:0], exp_gnt};
`ifdef IMEM_GNT_STALL_EN
    if (exp_gnt)            mstall[d] = STALL_N;
    else if (mstall[d] > 0) mstall[d] = mstall[d] - 1;
`endif
  endtask

  // Outputs are sampled mid-cycle; the model memory takes loads only after
  // both reads so a same-cycle load and fetch sees the old word.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitorStep(d);
    if (load_we && ((load_addr >> 2) < 32'(WORDS))) model_mem[load_addr[13:2]] = load_wdata;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [31:0] v);
    load_we    = 1'b1;
    load_addr  = a;
    load_wdata = v;
    @(posedge clk);
    #1;
    load_we = 1'b0;
  endtask

  // Presents one fetch and holds req until it is granted.
  task automatic applyStimulus(input int d, input logic [31:0] a);
    logic granted;
    int   waited;
    granted   = 1'b0;
    waited    = 0;
    req_w[d]  = 1'b1;
    addr_w[d] = a;
    while (!granted && waited < 50) begin
      @(negedge clk);
      granted = gnt_w[d];
      @(posedge clk);
      #1;
      waited++;
    end
    if (!granted) checkOutput("gnt_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rstn       = 1'b0;
    load_we    = 1'b0;
    load_addr  = 32'h0;
    load_wdata = 32'h0;
    for (int d = 0; d < 2; d++) begin
      req_w[d]  = 1'b0;
      addr_w[d] = 32'h0;
    end
    idle(3);
    rstn = 1'b1;

    loadWord(32'h0000_0000, 32'h0000_0013);
    loadWord(32'h0000_0004, 32'h0010_0093);
    loadWord(32'h0000_0008, 32'h0020_0113);
    loadWord(32'h0000_000C, 32'h0030_0193);
    for (int i = 4; i < 16; i++) loadWord(32'(i * 4), 32'(i) * 32'h0101_0101 + 32'h13);
    loadWord(32'h0000_4000, 32'hBAD0_0BAD);
    loadWord(32'hFFFF_FFF0, 32'hBAD1_1BAD);
    idle(1);

    fork
      begin
        applyStimulus(0, 32'h0000_0000);
        applyStimulus(0, 32'h0000_0004);
        applyStimulus(0, 32'h0000_4000);
        applyStimulus(0, 32'h0000_0006);
        applyStimulus(0, 32'hFFFF_FFFC);
        applyStimulus(0, 32'h0000_003C);
        applyStimulus(0, 32'h0000_0010);
        req_w[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'(i * 4));
        req_w[1] = 1'b0;
      end
    join
    idle(6);

    load_we    = 1'b1;
    load_addr  = 32'h0000_0008;
    load_wdata = 32'hDEAD_BEEF;
    req_w[0]   = 1'b1;
    addr_w[0]  = 32'h0000_0008;
    @(posedge clk);
    #1;
    load_we  = 1'b0;
    req_w[0] = 1'b0;
    idle(4);
    applyStimulus(0, 32'h0000_0008);
    req_w[0] = 1'b0;
    idle(4);

    applyStimulus(1, 32'h0000_0000);
    applyStimulus(1, 32'h0000_0004);
    req_w[1] = 1'b0;
    rstn     = 1'b0;
    idle(2);
    req_w[1]  = 1'b1;
    addr_w[1] = 32'h0000_000C;
    rstn      = 1'b1;
    applyStimulus(1, 32'h0000_000C);
    req_w[1] = 1'b0;

    idle(12);
    checkOutput("drain_a", 32'(q0.size()), 32'h0);
    checkOutput("drain_b", 32'(q1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
